// File: rtl/fma_ctrl_pkg.sv
// Shared definitions for the FMA alignment/sequencing controller and the
// exponent-difference helper reused by the normalizer exponent path.
package fma_ctrl_pkg;

   // Controller sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_MUL   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Width of the addend alignment window (3*(mantissa+hidden)+2 for single precision)
   localparam int ALIGN_WIDTH = 74;

   // Binary-point distance between the product and the unshifted addend
   localparam int POINT_DIST  = 27;

   // Product-path step counter, wide enough for up to 15 cycles
   localparam int MUL_CYCLES_MAX = 15;
   localparam int CNT_W          = $clog2(MUL_CYCLES_MAX + 1);

endpackage : fma_ctrl_pkg

// File: rtl/fma_exp_diff.sv
// Exponent difference for addend alignment: diff = Eb + Ec - bias + point - Ea,
// evaluated in PARM_EXP+3 bit two's complement so every operand combination fits.
// Purely combinational; the caller feeds registered exponents.
module fma_exp_diff
   import fma_ctrl_pkg::*;
#(
   parameter int PARM_EXP  = 8,
   parameter int PARM_BIAS = 127,
   parameter int ALIGN_W   = ALIGN_WIDTH,
   parameter int PT_DIST   = POINT_DIST
) (
   input  logic [PARM_EXP-1:0] exp_a_i,
   input  logic [PARM_EXP-1:0] exp_b_i,
   input  logic [PARM_EXP-1:0] exp_c_i,
   output logic                mv_sign_o,
   output logic                halt_o,
   output logic [PARM_EXP+1:0] mv_o
);

   localparam int DW = PARM_EXP + 3;

   logic [DW-1:0] diff;
   logic          neg;
   logic          too_far;

   // Wrapping unsigned arithmetic gives the correct two's-complement result in DW bits
   always_comb begin
      diff    = DW'(exp_b_i) + DW'(exp_c_i) - DW'(PARM_BIAS) + DW'(PT_DIST) - DW'(exp_a_i);
      neg     = diff[DW-1];
      too_far = ~neg && (diff >= DW'(ALIGN_W));
      mv_sign_o = neg;
      halt_o    = too_far;
      mv_o      = (~neg && ~too_far) ? diff[DW-2:0] : '0;
   end

endmodule : fma_exp_diff

// File: rtl/fma_align_ctrl.sv
// Sequencing controller for the single-precision FMA datapath (B*C +/- A).
// Accepts one operation at a time, presents the addend alignment controls,
// steps the product path and holds the result until the consumer takes it.
// Optional feature: define FMA_SPECIAL_BYPASS_EN to route special operands
// (all-ones exponent anywhere, or zero B/C exponent) straight to DONE.
module fma_align_ctrl
   import fma_ctrl_pkg::*;
#(
   parameter int PARM_EXP   = 8,
   parameter int PARM_MANT  = 23,
   parameter int PARM_BIAS  = 127,
   parameter int MUL_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_sub_i,
   input  logic                A_sign_i,
   input  logic                B_sign_i,
   input  logic                C_sign_i,
   input  logic [PARM_EXP-1:0] A_Exp_i,
   input  logic [PARM_EXP-1:0] B_Exp_i,
   input  logic [PARM_EXP-1:0] C_Exp_i,
   input  logic                flush_i,
   input  logic                res_ready_i,
   output logic                Sub_Sign_o,
   output logic [PARM_EXP+1:0] Exp_mv_o,
   output logic                Exp_mv_sign_o,
   output logic                Mv_halt_o,
   output logic                dp_en_o,
   output logic                mul_step_o,
   output logic                res_valid_o,
   output logic                special_o,
   output logic                busy_o
);

   // Alignment geometry follows from the mantissa width (74 / 27 for single precision)
   localparam int ALIGN_W  = 3 * (PARM_MANT + 1) + 2;
   localparam int PT_DIST  = PARM_MANT + 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                dp_en_q;
   logic                mul_step_q;
   logic                res_valid_q;
   logic                special_q;
   logic                ctrl_vld_q;
   logic                a_sign_q, b_sign_q, c_sign_q, sub_q;
   logic [PARM_EXP-1:0] a_exp_q, b_exp_q, c_exp_q;

   logic                mv_sign_d;
   logic                halt_d;
   logic [PARM_EXP+1:0] mv_d;

   // Alignment arithmetic from the captured exponents
   fma_exp_diff #(
      .PARM_EXP  (PARM_EXP),
      .PARM_BIAS (PARM_BIAS),
      .ALIGN_W   (ALIGN_W),
      .PT_DIST   (PT_DIST)
   ) u_exp_diff (
      .exp_a_i   (a_exp_q),
      .exp_b_i   (b_exp_q),
      .exp_c_i   (c_exp_q),
      .mv_sign_o (mv_sign_d),
      .halt_o    (halt_d),
      .mv_o      (mv_d)
   );

`ifdef FMA_SPECIAL_BYPASS_EN
   logic is_special;

   // Inf/NaN on any operand, or a zero/denormal multiplicand, needs no product path
   always_comb begin
      is_special = (&a_exp_q) | (&b_exp_q) | (&c_exp_q) | (b_exp_q == '0) | (c_exp_q == '0);
   end
`endif

   // Sequencer: state, step counter, operand capture and registered strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dp_en_q     <= 1'b0;
         mul_step_q  <= 1'b0;
         res_valid_q <= 1'b0;
         special_q   <= 1'b0;
         ctrl_vld_q  <= 1'b0;
         a_sign_q    <= 1'b0;
         b_sign_q    <= 1'b0;
         c_sign_q    <= 1'b0;
         sub_q       <= 1'b0;
         a_exp_q     <= '0;
         b_exp_q     <= '0;
         c_exp_q     <= '0;
      end else if (flush_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dp_en_q     <= 1'b0;
         mul_step_q  <= 1'b0;
         res_valid_q <= 1'b0;
         special_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  a_sign_q   <= A_sign_i;
                  b_sign_q   <= B_sign_i;
                  c_sign_q   <= C_sign_i;
                  sub_q      <= req_sub_i;
                  a_exp_q    <= A_Exp_i;
                  b_exp_q    <= B_Exp_i;
                  c_exp_q    <= C_Exp_i;
                  ctrl_vld_q <= 1'b1;
                  dp_en_q    <= 1'b1;
                  state_q    <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               dp_en_q <= 1'b0;
`ifdef FMA_SPECIAL_BYPASS_EN
               if (is_special) begin
                  special_q   <= 1'b1;
                  res_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  mul_step_q <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= ST_MUL;
               end
`else
               mul_step_q <= 1'b1;
               cnt_q      <= '0;
               state_q    <= ST_MUL;
`endif
            end
            ST_MUL: begin
               if (cnt_q == CNT_LAST) begin
                  mul_step_q  <= 1'b0;
                  res_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  special_q   <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Controls are derived only from captured operands; blanked until the first accept
   always_comb begin
      req_ready_o   = (state_q == ST_IDLE) & ~flush_i;
      busy_o        = (state_q != ST_IDLE);
      Sub_Sign_o    = ctrl_vld_q & (a_sign_q ^ sub_q ^ b_sign_q ^ c_sign_q);
      Exp_mv_o      = ctrl_vld_q ? mv_d : '0;
      Exp_mv_sign_o = ctrl_vld_q & mv_sign_d;
      Mv_halt_o     = ctrl_vld_q & halt_d;
      dp_en_o       = dp_en_q;
      mul_step_o    = mul_step_q;
      res_valid_o   = res_valid_q;
      special_o     = special_q;
   end

endmodule : fma_align_ctrl

// File: tb/tb_fma_align_ctrl.sv
// Directed bench for fma_align_ctrl at default parameters (MUL_CYCLES=4).
module tb_fma_align_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid_i = 1'b0;
   logic       req_ready_o;
   logic       req_sub_i = 1'b0;
   logic       A_sign_i = 1'b0, B_sign_i = 1'b0, C_sign_i = 1'b0;
   logic [7:0] A_Exp_i = '0, B_Exp_i = '0, C_Exp_i = '0;
   logic       flush_i = 1'b0;
   logic       res_ready_i = 1'b1;
   logic       Sub_Sign_o;
   logic [9:0] Exp_mv_o;
   logic       Exp_mv_sign_o, Mv_halt_o, dp_en_o, mul_step_o;
   logic       res_valid_o, special_o, busy_o;

   int checks = 0;
   int errors = 0;

   fma_align_ctrl #(
      .PARM_EXP   (8),
      .PARM_MANT  (23),
      .PARM_BIAS  (127),
      .MUL_CYCLES (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_sub_i     (req_sub_i),
      .A_sign_i      (A_sign_i),
      .B_sign_i      (B_sign_i),
      .C_sign_i      (C_sign_i),
      .A_Exp_i       (A_Exp_i),
      .B_Exp_i       (B_Exp_i),
      .C_Exp_i       (C_Exp_i),
      .flush_i       (flush_i),
      .res_ready_i   (res_ready_i),
      .Sub_Sign_o    (Sub_Sign_o),
      .Exp_mv_o      (Exp_mv_o),
      .Exp_mv_sign_o (Exp_mv_sign_o),
      .Mv_halt_o     (Mv_halt_o),
      .dp_en_o       (dp_en_o),
      .mul_step_o    (mul_step_o),
      .res_valid_o   (res_valid_o),
      .special_o     (special_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Offers one operation from IDLE and checks the full cycle-by-cycle sequence
   task automatic run_op(input string nm,
                         input logic [7:0] ae, input logic [7:0] be, input logic [7:0] ce,
                         input logic sa, input logic sb, input logic sc, input logic sub,
                         input int e_mv, input logic e_sgn, input logic e_halt,
                         input logic e_ss, input int hold);
      A_Exp_i = ae; B_Exp_i = be; C_Exp_i = ce;
      A_sign_i = sa; B_sign_i = sb; C_sign_i = sc; req_sub_i = sub;
      res_ready_i = (hold == 0);
      req_valid_i = 1'b1;
      #1 chk({nm, ".ready"}, 32'(req_ready_o), 1);
      next_cycle();
      req_valid_i = 1'b0;
      // cycle 1: ALIGN
      chk({nm, ".dp_en"}, 32'(dp_en_o), 1);
      chk({nm, ".mv"}, 32'(Exp_mv_o), 32'(e_mv));
      chk({nm, ".sgn"}, 32'(Exp_mv_sign_o), 32'(e_sgn));
      chk({nm, ".halt"}, 32'(Mv_halt_o), 32'(e_halt));
      chk({nm, ".sub"}, 32'(Sub_Sign_o), 32'(e_ss));
      chk({nm, ".c1_step"}, 32'(mul_step_o), 0);
      // cycles 2..5: MUL
      for (int k = 2; k <= 5; k++) begin
         next_cycle();
         chk($sformatf("%s.c%0d_step", nm, k), 32'(mul_step_o), 1);
         chk($sformatf("%s.c%0d_dp", nm, k), 32'(dp_en_o | res_valid_o), 0);
      end
      // cycle 6: DONE
      next_cycle();
      chk({nm, ".c6_valid"}, 32'(res_valid_o), 1);
      chk({nm, ".c6_step"}, 32'(mul_step_o), 0);
      chk({nm, ".c6_mv"}, 32'(Exp_mv_o), 32'(e_mv));
      for (int k = 0; k < hold; k++) begin
         next_cycle();
         chk({nm, ".hold_valid"}, 32'(res_valid_o), 1);
         chk({nm, ".hold_ready"}, 32'(req_ready_o), 0);
         chk({nm, ".hold_mv"}, 32'(Exp_mv_o), 32'(e_mv));
         chk({nm, ".hold_halt"}, 32'(Mv_halt_o), 32'(e_halt));
      end
      res_ready_i = 1'b1;
      next_cycle();
      chk({nm, ".idle_valid"}, 32'(res_valid_o), 0);
      chk({nm, ".idle_busy"}, 32'(busy_o), 0);
      chk({nm, ".idle_ready"}, 32'(req_ready_o), 1);
      $display("op %s A=%0d B=%0d C=%0d mv=%0d sgn=%0d halt=%0d sub=%0d", nm, ae, be, ce,
               Exp_mv_o, Exp_mv_sign_o, Mv_halt_o, Sub_Sign_o);
   endtask

   // Accepts an operation and advances to the given cycle after accept
   task automatic start_and_wait(input int cyc);
      A_Exp_i = 8'd127; B_Exp_i = 8'd127; C_Exp_i = 8'd127;
      A_sign_i = 1'b0; B_sign_i = 1'b0; C_sign_i = 1'b0; req_sub_i = 1'b0;
      req_valid_i = 1'b1;
      next_cycle();
      req_valid_i = 1'b0;
      for (int k = 1; k < cyc; k++) next_cycle();
   endtask

   initial begin
      int seen_valid;
      int seen_busy;

      // reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.ready", 32'(req_ready_o), 1);
      chk("rst.busy", 32'(busy_o), 0);
      chk("rst.valid", 32'(res_valid_o), 0);
      chk("rst.mv", 32'(Exp_mv_o), 0);
      chk("rst.sgn", 32'(Exp_mv_sign_o), 0);
      chk("rst.halt", 32'(Mv_halt_o), 0);
      chk("rst.sub", 32'(Sub_Sign_o), 0);
      chk("rst.strobes", 32'({dp_en_o, mul_step_o, special_o}), 0);
      rst_n = 1'b1;
      next_cycle();
      chk("post_rst.ready", 32'(req_ready_o), 1);

      // alignment vectors: diff = B + C - 127 + 27 - A
      run_op("nominal", 8'd127, 8'd127, 8'd127, 0, 0, 0, 0, 27, 0, 0, 0, 0);
      run_op("a_big",   8'd200, 8'd127, 8'd127, 0, 0, 0, 0, 0,  1, 0, 0, 0);
      run_op("edge73",  8'd81,  8'd127, 8'd127, 0, 0, 0, 0, 73, 0, 0, 0, 0);
      run_op("edge74",  8'd80,  8'd127, 8'd127, 0, 0, 0, 0, 0,  0, 1, 0, 0);
      run_op("far",     8'd1,   8'd200, 8'd200, 0, 0, 0, 0, 0,  0, 1, 0, 0);
      run_op("diff0",   8'd27,  8'd127, 8'd0,   0, 0, 0, 0, 0,  0, 0, 0, 0);
      run_op("diffm1",  8'd28,  8'd127, 8'd0,   0, 0, 0, 0, 0,  1, 0, 0, 0);
      // sign vectors
      run_op("sgn_a",   8'd127, 8'd127, 8'd127, 1, 0, 0, 0, 27, 0, 0, 1, 0);
      run_op("sgn_as",  8'd127, 8'd127, 8'd127, 1, 0, 0, 1, 27, 0, 0, 0, 0);
      run_op("sgn_bc",  8'd127, 8'd127, 8'd127, 0, 1, 1, 0, 27, 0, 0, 0, 0);
      run_op("sgn_b",   8'd127, 8'd127, 8'd127, 0, 1, 0, 0, 27, 0, 0, 1, 0);
      // back-pressure in DONE
      run_op("hold3",   8'd100, 8'd127, 8'd127, 0, 0, 1, 0, 54, 0, 0, 1, 3);

      // flush in MUL step 2 together with a new offer
      start_and_wait(3);
      chk("flush.pre_step", 32'(mul_step_o), 1);
      flush_i = 1'b1;
      req_valid_i = 1'b1;
      #1 chk("flush.ready", 32'(req_ready_o), 0);
      next_cycle();
      flush_i = 1'b0;
      req_valid_i = 1'b0;
      chk("flush.busy", 32'(busy_o), 0);
      chk("flush.step", 32'(mul_step_o), 0);
      chk("flush.dp", 32'(dp_en_o), 0);
      seen_valid = 0;
      seen_busy = 0;
      for (int k = 0; k < 8; k++) begin
         if (res_valid_o) seen_valid++;
         if (busy_o) seen_busy++;
         next_cycle();
      end
      chk("flush.never_valid", 32'(seen_valid), 0);
      chk("flush.no_accept", 32'(seen_busy), 0);
      $display("flush mid-MUL: valid_cycles=%0d busy_cycles=%0d", seen_valid, seen_busy);

      // asynchronous reset mid-MUL
      start_and_wait(3);
      chk("arst.pre_busy", 32'(busy_o), 1);
      rst_n = 1'b0;
      #1;
      chk("arst.busy", 32'(busy_o), 0);
      chk("arst.step", 32'(mul_step_o), 0);
      chk("arst.valid", 32'(res_valid_o), 0);
      chk("arst.mv", 32'(Exp_mv_o), 0);
      chk("arst.misc", 32'({dp_en_o, special_o, Sub_Sign_o, Exp_mv_sign_o, Mv_halt_o}), 0);
      $display("async reset mid-MUL: busy=%0d step=%0d mv=%0d", busy_o, mul_step_o, Exp_mv_o);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // recovery after reset
      run_op("recover", 8'd127, 8'd127, 8'd127, 0, 0, 0, 0, 27, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fma_align_ctrl
